// File: rtl/oled_init_ctrl.sv
// Power-up sequencer for an SSD1306-class OLED: pulses the panel reset, then
// streams CMD_COUNT command bytes from the command RAM over 4-wire SPI (mode 0).
//
// state    | meaning
// IDLE     | waiting for start; done holds the result of the last run
// RES_LOW  | panel reset asserted
// RES_WAIT | panel reset released, settling before the first fetch
// FETCH    | command RAM read issued for the current index
// LATCH    | RAM output captured into the shift register
// SHIFT    | byte clocked out MSB first, chip select low
// GAP      | chip select high between bytes
// DONE     | last byte sent, flags updated on exit
module oled_init_ctrl #(
  parameter int CMD_COUNT       = 26,
  parameter int ADDR_WIDTH      = 5,
  parameter int CLK_DIV         = 4,
  parameter int RES_LOW_CYCLES  = 1000,
  parameter int RES_WAIT_CYCLES = 1000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  cmd_re_n,
  output logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]            cmd_data,
  output logic                  oled_res_n,
  output logic                  oled_cs_n,
  output logic                  oled_dc,
  output logic                  oled_sclk,
  output logic                  oled_sdin,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {
    S_IDLE, S_RES_LOW, S_RES_WAIT, S_FETCH, S_LATCH, S_SHIFT, S_GAP, S_DONE
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(CMD_COUNT - 1);
  localparam logic [15:0] LOW_LOAD  = 16'(RES_LOW_CYCLES - 1);
  localparam logic [15:0] WAIT_LOAD = 16'(RES_WAIT_CYCLES - 1);
  localparam logic [15:0] DIV_LOAD  = 16'(CLK_DIV - 1);

  state_t                state, state_nxt;
  logic [15:0]           tmr, tmr_nxt;
  logic [2:0]            bit_cnt, bit_cnt_nxt;
  logic [7:0]            shreg, shreg_nxt;
  logic [ADDR_WIDTH-1:0] addr_nxt;
  logic                  re_n_nxt, res_n_nxt, cs_n_nxt, sclk_nxt, sdin_nxt;
  logic                  busy_nxt, done_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      tmr        <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      cmd_re_n   <= 1'b1;
      cmd_addr   <= '0;
      oled_res_n <= 1'b1;
      oled_cs_n  <= 1'b1;
      oled_dc    <= 1'b0;
      oled_sclk  <= 1'b0;
      oled_sdin  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      tmr        <= tmr_nxt;
      bit_cnt    <= bit_cnt_nxt;
      shreg      <= shreg_nxt;
      cmd_re_n   <= re_n_nxt;
      cmd_addr   <= addr_nxt;
      oled_res_n <= res_n_nxt;
      oled_cs_n  <= cs_n_nxt;
      oled_dc    <= 1'b0;
      oled_sclk  <= sclk_nxt;
      oled_sdin  <= sdin_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    tmr_nxt     = tmr;
    bit_cnt_nxt = bit_cnt;
    shreg_nxt   = shreg;
    re_n_nxt    = cmd_re_n;
    addr_nxt    = cmd_addr;
    res_n_nxt   = oled_res_n;
    cs_n_nxt    = oled_cs_n;
    sclk_nxt    = oled_sclk;
    sdin_nxt    = oled_sdin;
    busy_nxt    = busy;
    done_nxt    = done;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_RES_LOW;
          busy_nxt  = 1'b1;
          done_nxt  = 1'b0;
          addr_nxt  = '0;
          res_n_nxt = 1'b0;
          tmr_nxt   = LOW_LOAD;
        end
      end
      S_RES_LOW: begin
        if (tmr == 16'd0) begin
          state_nxt = S_RES_WAIT;
          res_n_nxt = 1'b1;
          tmr_nxt   = WAIT_LOAD;
        end else begin
          tmr_nxt = tmr - 16'd1;
        end
      end
      S_RES_WAIT: begin
        if (tmr == 16'd0) begin
          state_nxt = S_FETCH;
          re_n_nxt  = 1'b0;
        end else begin
          tmr_nxt = tmr - 16'd1;
        end
      end
      S_FETCH: begin
        state_nxt = S_LATCH;
        re_n_nxt  = 1'b1;
      end
      S_LATCH: begin
        // MSB goes straight to the pin; the rest waits in the shift register
        state_nxt   = S_SHIFT;
        shreg_nxt   = {cmd_data[6:0], 1'b0};
        sdin_nxt    = cmd_data[7];
        cs_n_nxt    = 1'b0;
        sclk_nxt    = 1'b0;
        bit_cnt_nxt = 3'd7;
        tmr_nxt     = DIV_LOAD;
      end
      S_SHIFT: begin
        if (tmr == 16'd0) begin
          tmr_nxt = DIV_LOAD;
          if (!oled_sclk) begin
            sclk_nxt = 1'b1;
          end else if (bit_cnt == 3'd0) begin
            state_nxt = S_GAP;
            cs_n_nxt  = 1'b1;
            sclk_nxt  = 1'b0;
          end else begin
            sclk_nxt    = 1'b0;
            sdin_nxt    = shreg[7];
            shreg_nxt   = {shreg[6:0], 1'b0};
            bit_cnt_nxt = bit_cnt - 3'd1;
          end
        end else begin
          tmr_nxt = tmr - 16'd1;
        end
      end
      S_GAP: begin
        if (tmr == 16'd0) begin
          if (cmd_addr == LAST_IDX) begin
            state_nxt = S_DONE;
          end else begin
            state_nxt = S_FETCH;
            addr_nxt  = cmd_addr + 1'b1;
            re_n_nxt  = 1'b0;
          end
        end else begin
          tmr_nxt = tmr - 16'd1;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_oled_init_ctrl.sv
// Bench for oled_init_ctrl: three parameterisations checked every cycle against a
// timeline model derived from cycles-since-start, plus SPI byte decoding.
module tb_oled_init_ctrl;

  localparam int P_N[3]  = '{26, 1, 4};
  localparam int P_CD[3] = '{4, 1, 2};
  localparam int P_RL[3] = '{1000, 1, 3};
  localparam int P_RW[3] = '{1000, 1, 2};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] start_v = 3'b000;

  logic       re_n_a, res_n_a, cs_n_a, dc_a, sclk_a, sdin_a, busy_a, done_a;
  logic       re_n_b, res_n_b, cs_n_b, dc_b, sclk_b, sdin_b, busy_b, done_b;
  logic       re_n_c, res_n_c, cs_n_c, dc_c, sclk_c, sdin_c, busy_c, done_c;
  logic [4:0] addr_a, addr_b;
  logic [1:0] addr_c;
  logic [7:0] data_a, data_b, data_c;
  logic [7:0] rom [32];

  logic [11:0] act_v [3];
  logic [2:0]  sdin_v, done_v;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  oled_init_ctrl #(.CMD_COUNT(P_N[0]), .ADDR_WIDTH(5), .CLK_DIV(P_CD[0]),
                   .RES_LOW_CYCLES(P_RL[0]), .RES_WAIT_CYCLES(P_RW[0])) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .cmd_re_n(re_n_a), .cmd_addr(addr_a),
    .cmd_data(data_a), .oled_res_n(res_n_a), .oled_cs_n(cs_n_a), .oled_dc(dc_a),
    .oled_sclk(sclk_a), .oled_sdin(sdin_a), .busy(busy_a), .done(done_a));

  oled_init_ctrl #(.CMD_COUNT(P_N[1]), .ADDR_WIDTH(5), .CLK_DIV(P_CD[1]),
                   .RES_LOW_CYCLES(P_RL[1]), .RES_WAIT_CYCLES(P_RW[1])) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .cmd_re_n(re_n_b), .cmd_addr(addr_b),
    .cmd_data(data_b), .oled_res_n(res_n_b), .oled_cs_n(cs_n_b), .oled_dc(dc_b),
    .oled_sclk(sclk_b), .oled_sdin(sdin_b), .busy(busy_b), .done(done_b));

  // Full-range index: CMD_COUNT equals 2^ADDR_WIDTH
  oled_init_ctrl #(.CMD_COUNT(P_N[2]), .ADDR_WIDTH(2), .CLK_DIV(P_CD[2]),
                   .RES_LOW_CYCLES(P_RL[2]), .RES_WAIT_CYCLES(P_RW[2])) dut_c (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .cmd_re_n(re_n_c), .cmd_addr(addr_c),
    .cmd_data(data_c), .oled_res_n(res_n_c), .oled_cs_n(cs_n_c), .oled_dc(dc_c),
    .oled_sclk(sclk_c), .oled_sdin(sdin_c), .busy(busy_c), .done(done_c));

  always @(posedge clk) begin
    if (!re_n_a) data_a <= rom[addr_a];
    if (!re_n_b) data_b <= rom[addr_b];
    if (!re_n_c) data_c <= rom[addr_c];
  end

  assign act_v[0] = {busy_a, done_a, res_n_a, cs_n_a, dc_a, sclk_a, re_n_a, addr_a};
  assign act_v[1] = {busy_b, done_b, res_n_b, cs_n_b, dc_b, sclk_b, re_n_b, addr_b};
  assign act_v[2] = {busy_c, done_c, res_n_c, cs_n_c, dc_c, sclk_c, re_n_c, 3'b000, addr_c};
  assign sdin_v   = {sdin_c, sdin_b, sdin_a};
  assign done_v   = {done_c, done_b, done_a};

  function automatic int total(input int i);
    return P_RL[i] + P_RW[i] + P_N[i] * (2 + 17 * P_CD[i]) + 1;
  endfunction

  // Expected outputs t cycles after start acceptance:
  // {sdin_valid, sdin, busy, done, res_n, cs_n, dc, sclk, re_n, addr[4:0]}
  function automatic logic [13:0] model(input int i, input bit started, input int t);
    int p, u, k, o, s, cd;
    logic [4:0] addr;
    logic bsy, dn, res_n, cs_n, sclk, re_n, sdin, vld;
    cd = P_CD[i];
    p = 2 + 17 * cd;
    bsy = 1'b0; dn = 1'b0; res_n = 1'b1; cs_n = 1'b1; sclk = 1'b0;
    re_n = 1'b1; sdin = 1'b0; vld = 1'b0; addr = 5'd0;
    if (started) begin
      if (t > total(i)) begin
        dn = 1'b1;
        addr = 5'(P_N[i] - 1);
      end else begin
        bsy = 1'b1;
        if (t <= P_RL[i]) begin
          res_n = 1'b0;
        end else if (t > P_RL[i] + P_RW[i]) begin
          u = t - P_RL[i] - P_RW[i] - 1;
          if (u >= P_N[i] * p) begin
            addr = 5'(P_N[i] - 1);
          end else begin
            k = u / p;
            o = u % p;
            addr = 5'(k);
            if (o == 0) re_n = 1'b0;
            else if (o >= 2 && o < 2 + 16 * cd) begin
              s = o - 2;
              cs_n = 1'b0;
              vld = 1'b1;
              sclk = ((s % (2 * cd)) >= cd);
              sdin = rom[k][7 - s / (2 * cd)];
            end
          end
        end
      end
    end
    return {vld, sdin, bsy, dn, res_n, cs_n, 1'b0, sclk, re_n, addr};
  endfunction

  bit m_started [3];
  int m_t [3];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        m_started[i] <= 1'b0;
        m_t[i] <= 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (start_v[i] && (!m_started[i] || m_t[i] > total(i))) begin
          m_started[i] <= 1'b1;
          m_t[i] <= 1;
        end else if (m_started[i] && m_t[i] <= total(i)) begin
          m_t[i] <= m_t[i] + 1;
        end
      end
    end
  end

  logic [13:0] cmp_e;
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        cmp_e = model(i, m_started[i], m_t[i]);
        checks++;
        if (act_v[i] !== cmp_e[11:0]) begin
          errors++;
          $display("FAIL outputs[%0d] t=%0d actual=%h required=%h", i, m_t[i], act_v[i], cmp_e[11:0]);
        end
        if (cmp_e[13]) begin
          checks++;
          if (sdin_v[i] !== cmp_e[12]) begin
            errors++;
            $display("FAIL sdin[%0d] t=%0d actual=%b required=%b", i, m_t[i], sdin_v[i], cmp_e[12]);
          end
        end
      end
    end
  end

  logic [7:0] dec_a [$];
  logic [7:0] dec_b [$];
  int         addr_q [$];
  logic [7:0] sh_a = 8'h00, sh_b = 8'h00;
  int         nb_a = 0, nb_b = 0;

  initial begin
    forever begin
      @(posedge sclk_a or posedge cs_n_a);
      if (cs_n_a) begin
        if (nb_a == 8) dec_a.push_back(sh_a);
        nb_a = 0;
      end else begin
        sh_a = {sh_a[6:0], sdin_a};
        nb_a++;
      end
    end
  end

  initial begin
    forever begin
      @(posedge sclk_b or posedge cs_n_b);
      if (cs_n_b) begin
        if (nb_b == 8) dec_b.push_back(sh_b);
        nb_b = 0;
      end else begin
        sh_b = {sh_b[6:0], sdin_b};
        nb_b++;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (re_n_a === 1'b0) addr_q.push_back(int'(addr_a));
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic pulse_start(input int i);
    @(negedge clk);
    start_v[i] = 1'b1;
    @(posedge clk);
    #1;
    start_v[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, output int n);
    n = 0;
    while (done_v[i] !== 1'b1 && n < 6000) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  int n;

  initial begin
    rom = '{8'hae, 8'h81, 8'hff, 8'ha6, 8'h20, 8'h02, 8'h00, 8'h10,
            8'h40, 8'ha1, 8'hc8, 8'ha8, 8'h1f, 8'hd3, 8'h00, 8'hd5,
            8'h80, 8'hd9, 8'h1f, 8'hda, 8'h02, 8'hdb, 8'h40, 8'h8d,
            8'ha4, 8'haf, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

    // Reset held with start high: nothing may move
    start_v = 3'b111;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy_a), 0);
    chk("rst_done", int'(done_a), 0);
    chk("rst_res_n", int'(res_n_a), 1);
    chk("rst_cs_n", int'(cs_n_a), 1);
    chk("rst_re_n", int'(re_n_a), 1);
    chk("rst_addr", int'(addr_a), 0);
    chk("rst_sclk", int'(sclk_a), 0);
    chk("rst_sdin", int'(sdin_a), 0);
    chk("rst_dc", int'(dc_a), 0);
    chk("rst_busy_b", int'(busy_b), 0);
    @(negedge clk);
    start_v = 3'b000;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Full sequence with a second start during SHIFT of byte 5
    pulse_start(0);
    chk("start_busy", int'(busy_a), 1);
    chk("start_res_n", int'(res_n_a), 0);
    n = 0;
    while (done_a !== 1'b1 && n < 6000) begin
      @(posedge clk);
      #1;
      n++;
      start_v[0] = (n == 2361);
    end
    start_v[0] = 1'b0;
    chk("done_latency_a", n, 3821);
    chk("busy_after_done", int'(busy_a), 0);
    chk("byte_count_a", dec_a.size(), 26);
    for (int k = 0; k < 26; k++)
      if (k < dec_a.size()) chk($sformatf("byte_a[%0d]", k), int'(dec_a[k]), int'(rom[k]));
    chk("fetch_count_a", addr_q.size(), 26);
    for (int k = 0; k < 26; k++)
      if (k < addr_q.size()) chk($sformatf("fetch_addr[%0d]", k), addr_q[k], k);

    // Restart, then async reset in the middle of byte 10
    dec_a.delete();
    addr_q.delete();
    pulse_start(0);
    chk("restart_done_clr", int'(done_a), 0);
    chk("restart_res_n", int'(res_n_a), 0);
    n = 0;
    while (!(addr_a == 5'd10 && cs_n_a == 1'b0 && nb_a == 3) && n < 6000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("reached_byte10_bit3", int'(n < 6000), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_cs_n", int'(cs_n_a), 1);
    chk("async_sclk", int'(sclk_a), 0);
    chk("async_sdin", int'(sdin_a), 0);
    chk("async_busy", int'(busy_a), 0);
    chk("async_addr", int'(addr_a), 0);
    chk("async_res_n", int'(res_n_a), 1);
    chk("bytes_before_reset", dec_a.size(), 10);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dec_a.delete();
    addr_q.delete();
    repeat (2) @(negedge clk);
    pulse_start(0);
    chk("after_reset_res_n", int'(res_n_a), 0);
    wait_done(0, n);
    chk("done_latency_a2", n, 3821);
    chk("byte_count_a2", dec_a.size(), 26);
    if (dec_a.size() > 0) chk("first_byte_a2", int'(dec_a[0]), 8'hae);
    if (addr_q.size() > 0) chk("first_fetch_a2", addr_q[0], 0);

    // Minimal configuration: one byte, CLK_DIV=1
    pulse_start(1);
    wait_done(1, n);
    chk("done_latency_b", n, 22);
    chk("byte_count_b", dec_b.size(), 1);
    if (dec_b.size() > 0) chk("byte_b", int'(dec_b[0]), 8'hae);
    pulse_start(1);
    chk("restart_done_b", int'(done_b), 0);
    chk("restart_busy_b", int'(busy_b), 1);
    wait_done(1, n);
    chk("done_latency_b2", n, 22);
    chk("byte_count_b2", dec_b.size(), 2);

    // Index reaches all-ones without wrapping
    pulse_start(2);
    wait_done(2, n);
    chk("done_latency_c", n, 150);
    chk("last_addr_c", int'(addr_c), 3);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/oled_init_ctrl.md
# oled_init_ctrl

Power-up sequencer and SPI command transmitter for the SSD1306-class OLED. It sits directly downstream of the OLED command RAM. On `start` it pulses the panel reset, then walks command addresses 0..CMD_COUNT-1, reads each byte from the RAM and shifts it to the panel over 4-wire SPI with D/C low. It reports completion to the display-data path.

## Interface
- `CMD_COUNT`, 26: number of command bytes to send; legal range 1..2^ADDR_WIDTH.
- `ADDR_WIDTH`, 5: command RAM address width.
- `CLK_DIV`, 4: clk cycles per SCLK half-period; must be ≥1.
- `RES_LOW_CYCLES`, 1000: clk cycles `oled_res_n` is held low; must be ≥1 and <2^16.
- `RES_WAIT_CYCLES`, 1000: clk cycles waited after reset release before the first fetch; must be ≥1 and <2^16.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle request to run the init sequence.
- `cmd_re_n`  out  1  read enable to the command RAM, active low.
- `cmd_addr`  out  ADDR_WIDTH  command RAM address.
- `cmd_data`  in  8  registered RAM output; valid the cycle after `cmd_re_n`=0 is sampled.
- `oled_res_n`  out  1  panel reset.
- `oled_cs_n`  out  1  SPI chip select.
- `oled_dc`  out  1  data/command select; 0 = command.
- `oled_sclk`  out  1  SPI clock, mode 0.
- `oled_sdin`  out  1  SPI data, MSB first.
- `busy`  out  1  high from `start` acceptance until `done`.
- `done`  out  1  sticky; high after the last byte, cleared on the next accepted `start`.

## Operation
- Reset values: `cmd_re_n`=1, `cmd_addr`=0, `oled_res_n`=1, `oled_cs_n`=1, `oled_dc`=0, `oled_sclk`=0, `oled_sdin`=0, `busy`=0, `done`=0, state=IDLE.
- All outputs are registered.
- State machine:
  - IDLE: on `start` → RES_LOW. Set `busy`=1, clear `done`, clear the index.
  - RES_LOW: `oled_res_n`=0 for RES_LOW_CYCLES cycles → RES_WAIT.
  - RES_WAIT: `oled_res_n`=1 for RES_WAIT_CYCLES cycles → FETCH.
  - FETCH (1 cycle): `cmd_re_n`=0, `cmd_addr`=index → LATCH.
  - LATCH (1 cycle): `cmd_re_n`=1. Load `cmd_data` into the 8-bit shift register → SHIFT.
  - SHIFT: `oled_cs_n`=0, `oled_dc`=0. Send 8 bits, MSB first, 2·CLK_DIV cycles per bit:
    - Low phase: `oled_sdin` is updated on the first cycle, and `oled_sclk`=0 for CLK_DIV cycles.
    - High phase: `oled_sclk`=1 for CLK_DIV cycles.
    - After bit 0's high phase → GAP.
  - GAP: `oled_cs_n`=1, `oled_sclk`=0 for CLK_DIV cycles.
    - If index = CMD_COUNT-1 → DONE.
    - Otherwise increment the index → FETCH.
  - DONE (1 cycle): `busy`=0, `done`=1 → IDLE.
- `start` is ignored while `busy`=1. `start` in IDLE with `done`=1 restarts the full sequence, including the panel reset.
- The index never wraps. The terminal compare stops at CMD_COUNT-1, so with CMD_COUNT=2^ADDR_WIDTH the last address is all-ones.
- When `rst_n` is asserted mid-operation, all outputs take their reset values immediately (asynchronously). A partially sent byte is abandoned; no resume.

## Timing
- `start` sampled high in IDLE: `busy` and `oled_res_n`=0 are both visible the next cycle.
- Per-byte cost: 1 (FETCH) + 1 (LATCH) + 16·CLK_DIV (SHIFT) + CLK_DIV (GAP). With defaults this is 70 cycles.
- Total from accepted `start` to `done`=1: RES_LOW_CYCLES + RES_WAIT_CYCLES + CMD_COUNT·(2+17·CLK_DIV) + 1.
- `oled_sdin` is stable for the whole SCLK high phase and changes only while SCLK is low, satisfying mode 0.
- `oled_cs_n` falls on the same cycle the first bit is driven. It rises on the cycle after the last SCLK high phase ends.

## Test plan
- Reset check: hold `rst_n`=0 with `start`=1 → every output at its reset value; `busy` stays 0.
- Full sequence: behavioural RAM model preloaded with the 26-byte init table, pulse `start` → the SPI monitor decodes exactly ae,81,ff,a6,20,02,00,10,40,a1,c8,a8,1f,d3,00,d5,80,d9,1f,da,02,db,40,8d,a4,af with `oled_dc`=0 throughout.
  - `done` rises exactly 1000+1000+26·70+1 = 3821 cycles after `start` is accepted.
- Handshake: check that `cmd_re_n`=0 lasts exactly one cycle per byte, with `cmd_addr` equal to 0..25 in order.
- Busy protection: pulse `start` again during SHIFT of byte 5 → no restart; the byte stream is unchanged.
- Async reset: drop `rst_n` in the middle of bit 3 of byte 10 → outputs reset within the same cycle.
  - After release and a fresh `start`, the sequence restarts at address 0 with a new `oled_res_n` pulse.
- Boundary: CMD_COUNT=1, CLK_DIV=1, RES_LOW/WAIT=1 → exactly one byte is sent (ae), and `done` rises at cycle 1+1+19+1 = 22 after `start`.
  - A second `start` clears `done` and repeats the sequence.
